block_spawner: RTL and testbench
================================

Name: block_spawner

Overview:
- Upstream sequencer for the falling-block instances.
- Each frame_clk it walks a fixed level pattern of gap/column entries and assigns each entry to a free block slot.
- For that slot it drives block_ready and the block's X centre.
- Tracks per-slot busy/retired status from each block's end_level and collision inputs, and flags level completion.

Parameters:
- NUM_SLOTS, 4, number of block instances driven (max 8).
- PATTERN_LEN, 16, entries in level pattern (max 31).
- X_BASE, 10'd80, X centre of column 0.
- COL_PITCH, 10'd80, X spacing between columns; columns 0-5 valid.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level start request; sampled in IDLE only.
- restart  in  1  synchronous abort to IDLE; sampled every edge.
- slot_end  in  NUM_SLOTS  per-slot end_level from block (block left screen).
- slot_hit  in  NUM_SLOTS  per-slot collision (block returned to Y=0).
- block_ready  out  NUM_SLOTS  per-slot release; high while slot busy.
- block_x_center  out  NUM_SLOTS x 10  per-slot X centre.
- level_done  out  1  level finished, held until restart/Reset.
- level_truncated  out  1  level ended early because all slots retired.
- blocks_released  out  5  count of pattern entries released.
- spawn_state  out  2  current FSM state, for debug/HUD.

Behaviour:
- Reset (async) state:
  - FSM = IDLE, idx = 0, busy = 0, retired = 0, gap_cnt = 0.
  - All block_ready = 0, all block_x_center = X_BASE.
  - level_done = 0, level_truncated = 0, blocks_released = 0.
- restart:
  - Synchronous; has priority over every other event.
  - Next edge gives the same state as Reset.
- Pattern entry format: gap[7:0] frames, col[2:0].
  - X = X_BASE + col*COL_PITCH, 10-bit, truncating.
  - col > 5 is clamped to 5.
- FSM:
  - IDLE: on start=1, load gap_cnt from entry[0].gap and go to WAIT.
  - WAIT:
    - gap_cnt decrements each frame.
    - When gap_cnt is 0 or 1, go to RELEASE next edge.
    - gap=0 behaves as gap=1, i.e. at least one frame in WAIT.
  - RELEASE:
    - Choose the lowest-index slot with busy=0 and retired=0, using the registered (pre-edge) flags.
    - On the same edge: set busy, block_ready=1, load block_x_center, increment blocks_released and idx.
    - If idx reaches PATTERN_LEN, go to DRAIN; otherwise load the next gap and go to WAIT.
    - If no slot is free, stall in RELEASE without consuming the entry.
    - If every slot is retired, go to DONE with level_truncated=1.
  - DRAIN: when busy==0 for all slots, go to DONE.
  - DONE: level_done=1; hold until restart or Reset. start is ignored.
- Slot status updates (every edge, in every state except IDLE):
  - slot_hit[i]: busy[i]<=0, block_ready[i]<=0; slot reusable (block is parked at Y=0).
  - slot_end[i] with no hit: busy[i]<=0, retired[i]<=1, block_ready[i]<=0. A retired slot is never reallocated before restart.
  - hit and end in the same cycle on one slot: hit wins; not retired.
- Freed-slot timing: a slot freed on edge N is not eligible for release until edge N+1.
- block_x_center[i] changes only on the release edge of slot i; it is stable while busy.
- slot_* inputs arriving on a non-busy slot are ignored.
- Latency: from WAIT expiry to block_ready high is exactly one frame_clk edge.

Decomposition:
- Shared package spawn_pkg holds:
  - spawn_state_t enum {IDLE, WAIT, RELEASE, DRAIN_DONE encoding}.
  - spawn_entry_t struct {gap[7:0], col[2:0]}.
  - COL_PITCH/X_BASE defaults and MAX_COL=5.
- Sub-module spawn_pattern_rom:
  - Combinational case table, idx[4:0] -> spawn_entry_t.
  - Swappable per level.

Test Plan:
- Reset mid-WAIT (gap_cnt=5, one slot busy): all outputs return to their reset values at once, asynchronously, before the next edge.
- start with entry0={gap=3,col=2}: block_ready[0] rises on the 4th edge after start; block_x_center[0]=240 on that edge; blocks_released=1.
- All 4 slots busy and entry pending: FSM stays in RELEASE, idx unchanged. slot_hit[2] pulse -> slot 2 released one edge later with the new X.
- Simultaneous slot_hit[1] and slot_end[1]: slot 1 not retired and reallocated on the next release. slot_end[3] alone: slot 3 never reused; released blocks go to slots 0-2.
- End of pattern: 16 releases, then all slots freed -> level_done=1, spawn_state=DONE, level_truncated=0. A start pulse in DONE does nothing.
- All slots retired with entries remaining -> level_done=1 and level_truncated=1. restart -> IDLE, counters 0; a new start replays from entry 0.

Source files
------------

// File: rtl/spawn_pkg.sv
// Shared types and helpers for the falling-block spawner: FSM encodings,
// pattern entry layout and column-to-X conversion.
package spawn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    RELEASE    = 2'd2,
    DRAIN_DONE = 2'd3
  } spawn_state_t;

  // DRAIN and DONE share one external code; level_done tells them apart
  typedef enum logic [2:0] {
    FSM_IDLE    = 3'd0,
    FSM_WAIT    = 3'd1,
    FSM_RELEASE = 3'd2,
    FSM_DRAIN   = 3'd3,
    FSM_DONE    = 3'd4
  } fsm_state_t;

  typedef struct packed {
    logic [7:0] gap;
    logic [2:0] col;
  } spawn_entry_t;

  localparam logic [9:0] X_BASE_DEF    = 10'd80;
  localparam logic [9:0] COL_PITCH_DEF = 10'd80;
  localparam logic [2:0] MAX_COL       = 3'd5;

  function automatic logic [9:0] col_to_x(input logic [2:0] col,
                                          input logic [9:0] base,
                                          input logic [9:0] pitch);
    logic [2:0] c;
    if (col > MAX_COL) c = MAX_COL;
    else               c = col;
    return base + ({7'd0, c} * pitch);
  endfunction

  function automatic spawn_state_t to_spawn_state(input fsm_state_t s);
    case (s)
      FSM_IDLE:    return IDLE;
      FSM_WAIT:    return WAIT;
      FSM_RELEASE: return RELEASE;
      FSM_DRAIN:   return DRAIN_DONE;
      FSM_DONE:    return DRAIN_DONE;
      default:     return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/block_spawner_if.sv
// Control/status bundle between the spawner and the block instances.
interface block_spawner_if #(parameter int NUM_SLOTS = 4);
  import spawn_pkg::*;

  logic                      start;
  logic                      restart;
  logic [NUM_SLOTS-1:0]      slot_end;
  logic [NUM_SLOTS-1:0]      slot_hit;
  logic [NUM_SLOTS-1:0]      block_ready;
  logic [NUM_SLOTS-1:0][9:0] block_x_center;
  logic                      level_done;
  logic                      level_truncated;
  logic [4:0]                blocks_released;
  spawn_state_t              spawn_state;

  modport master (
    output start, restart, slot_end, slot_hit,
    input  block_ready, block_x_center, level_done, level_truncated,
           blocks_released, spawn_state
  );

  modport slave (
    input  start, restart, slot_end, slot_hit,
    output block_ready, block_x_center, level_done, level_truncated,
           blocks_released, spawn_state
  );

endinterface

// File: rtl/spawn_pattern_rom.sv
// Level pattern table: idx -> {gap frames, column}. Swap this file per level.
module spawn_pattern_rom
  import spawn_pkg::*;
(
  input  logic [4:0]   idx,
  output spawn_entry_t entry
);

  // Level 1 pattern lookup
  always_comb begin
    entry = '{gap: 8'd1, col: 3'd0};
    case (idx)
      5'd0:    entry = '{gap: 8'd3, col: 3'd2};
      5'd1:    entry = '{gap: 8'd6, col: 3'd0};
      5'd2:    entry = '{gap: 8'd0, col: 3'd5};
      5'd3:    entry = '{gap: 8'd2, col: 3'd7};
      5'd4:    entry = '{gap: 8'd1, col: 3'd1};
      5'd5:    entry = '{gap: 8'd1, col: 3'd3};
      5'd6:    entry = '{gap: 8'd2, col: 3'd4};
      5'd7:    entry = '{gap: 8'd1, col: 3'd6};
      5'd8:    entry = '{gap: 8'd1, col: 3'd0};
      5'd9:    entry = '{gap: 8'd1, col: 3'd1};
      5'd10:   entry = '{gap: 8'd1, col: 3'd2};
      5'd11:   entry = '{gap: 8'd1, col: 3'd3};
      5'd12:   entry = '{gap: 8'd1, col: 3'd4};
      5'd13:   entry = '{gap: 8'd1, col: 3'd5};
      5'd14:   entry = '{gap: 8'd1, col: 3'd0};
      5'd15:   entry = '{gap: 8'd1, col: 3'd1};
      default: entry = '{gap: 8'd1, col: 3'd0};
    endcase
  end

endmodule

// File: rtl/block_spawner.sv
// Walks the level pattern once per frame, hands each entry to the lowest free
// block slot and tracks per-slot busy/retired status until the level ends.
module block_spawner
  import spawn_pkg::*;
#(
  parameter int         NUM_SLOTS   = 4,
  parameter int         PATTERN_LEN = 16,
  parameter logic [9:0] X_BASE      = X_BASE_DEF,
  parameter logic [9:0] COL_PITCH   = COL_PITCH_DEF
) (
  input logic           frame_clk,
  input logic           Reset,
  block_spawner_if.slave bus
);

  localparam int         SEL_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [4:0] PAT_LAST = 5'(PATTERN_LEN);

  fsm_state_t                state_r, state_nxt_s;
  logic [4:0]                idx_r, idx_nxt_s, next_idx_s, rom_addr_s;
  logic [7:0]                gap_cnt_r, gap_cnt_nxt_s;
  logic [2:0]                col_r, col_nxt_s;
  logic [NUM_SLOTS-1:0]      busy_r, busy_nxt_s;
  logic [NUM_SLOTS-1:0]      retired_r, retired_nxt_s;
  logic [NUM_SLOTS-1:0]      free_s;
  logic [NUM_SLOTS-1:0][9:0] x_r, x_nxt_s;
  logic                      level_done_r, level_done_nxt_s;
  logic                      trunc_r, trunc_nxt_s;
  logic [4:0]                released_r, released_nxt_s;
  logic [SEL_W-1:0]          sel_s;
  logic                      free_any_s, all_retired_s, all_idle_s;
  logic                      gap_expired_s, last_entry_s, rel_fire_s;
  logic [9:0]                rel_x_s;
  spawn_entry_t              rom_entry_s;

  // In IDLE fetch entry 0; otherwise prefetch the entry after the current one
  assign next_idx_s = idx_r + 5'd1;
  assign rom_addr_s = (state_r == FSM_IDLE) ? 5'd0 : next_idx_s;

  spawn_pattern_rom u_rom (
    .idx   (rom_addr_s),
    .entry (rom_entry_s)
  );

  assign free_s        = ~busy_r & ~retired_r;
  assign free_any_s    = |free_s;
  assign all_retired_s = &retired_r;
  assign all_idle_s    = (busy_r == {NUM_SLOTS{1'b0}});
  assign gap_expired_s = (gap_cnt_r <= 8'd1);
  assign last_entry_s  = (next_idx_s == PAT_LAST);
  assign rel_x_s       = col_to_x(col_r, X_BASE, COL_PITCH);
  assign rel_fire_s    = (state_r == FSM_RELEASE) && !all_retired_s && free_any_s;

  // Lowest-index slot that is neither busy nor retired
  always_comb begin
    sel_s = {SEL_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_s[i]) sel_s = SEL_W'(i);
      else           sel_s = sel_s;
    end
  end

  // FSM state register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)            state_r <= FSM_IDLE;
    else if (bus.restart) state_r <= FSM_IDLE;
    else                  state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FSM_IDLE: begin
        if (bus.start) state_nxt_s = FSM_WAIT;
        else           state_nxt_s = FSM_IDLE;
      end
      FSM_WAIT: begin
        if (gap_expired_s) state_nxt_s = FSM_RELEASE;
        else               state_nxt_s = FSM_WAIT;
      end
      FSM_RELEASE: begin
        if (all_retired_s)     state_nxt_s = FSM_DONE;
        else if (!free_any_s)  state_nxt_s = FSM_RELEASE;
        else if (last_entry_s) state_nxt_s = FSM_DRAIN;
        else                   state_nxt_s = FSM_WAIT;
      end
      FSM_DRAIN: begin
        if (all_idle_s) state_nxt_s = FSM_DONE;
        else            state_nxt_s = FSM_DRAIN;
      end
      FSM_DONE: state_nxt_s = FSM_DONE;
      default:  state_nxt_s = FSM_IDLE;
    endcase
  end

  // FSM output logic: next values for slot flags, counters and X centres
  always_comb begin
    idx_nxt_s        = idx_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    col_nxt_s        = col_r;
    busy_nxt_s       = busy_r;
    retired_nxt_s    = retired_r;
    x_nxt_s          = x_r;
    released_nxt_s   = released_r;
    level_done_nxt_s = level_done_r;
    trunc_nxt_s      = trunc_r;

    // A hit parks the block at Y=0 so the slot is reusable; end alone retires it
    if (state_r != FSM_IDLE) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (busy_r[i] && bus.slot_hit[i]) begin
          busy_nxt_s[i] = 1'b0;
        end else if (busy_r[i] && bus.slot_end[i]) begin
          busy_nxt_s[i]    = 1'b0;
          retired_nxt_s[i] = 1'b1;
        end else begin
          busy_nxt_s[i] = busy_r[i];
        end
      end
    end else begin
      busy_nxt_s = busy_r;
    end

    case (state_r)
      FSM_IDLE: begin
        if (bus.start) begin
          gap_cnt_nxt_s = rom_entry_s.gap;
          col_nxt_s     = rom_entry_s.col;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r;
        end
      end
      FSM_WAIT: begin
        if (gap_cnt_r != 8'd0) gap_cnt_nxt_s = gap_cnt_r - 8'd1;
        else                   gap_cnt_nxt_s = 8'd0;
      end
      FSM_RELEASE: begin
        if (rel_fire_s) begin
          busy_nxt_s[sel_s] = 1'b1;
          x_nxt_s[sel_s]    = rel_x_s;
          released_nxt_s    = released_r + 5'd1;
          idx_nxt_s         = next_idx_s;
          gap_cnt_nxt_s     = rom_entry_s.gap;
          col_nxt_s         = rom_entry_s.col;
        end else if (all_retired_s) begin
          level_done_nxt_s = 1'b1;
          trunc_nxt_s      = 1'b1;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      FSM_DRAIN: begin
        if (all_idle_s) level_done_nxt_s = 1'b1;
        else            level_done_nxt_s = 1'b0;
      end
      FSM_DONE: level_done_nxt_s = 1'b1;
      default:  level_done_nxt_s = level_done_r;
    endcase
  end

  // Datapath registers; restart behaves exactly like Reset on the next edge
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      idx_r        <= 5'd0;
      gap_cnt_r    <= 8'd0;
      col_r        <= 3'd0;
      busy_r       <= {NUM_SLOTS{1'b0}};
      retired_r    <= {NUM_SLOTS{1'b0}};
      x_r          <= {NUM_SLOTS{X_BASE}};
      released_r   <= 5'd0;
      level_done_r <= 1'b0;
      trunc_r      <= 1'b0;
    end else if (bus.restart) begin
      idx_r        <= 5'd0;
      gap_cnt_r    <= 8'd0;
      col_r        <= 3'd0;
      busy_r       <= {NUM_SLOTS{1'b0}};
      retired_r    <= {NUM_SLOTS{1'b0}};
      x_r          <= {NUM_SLOTS{X_BASE}};
      released_r   <= 5'd0;
      level_done_r <= 1'b0;
      trunc_r      <= 1'b0;
    end else begin
      idx_r        <= idx_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      col_r        <= col_nxt_s;
      busy_r       <= busy_nxt_s;
      retired_r    <= retired_nxt_s;
      x_r          <= x_nxt_s;
      released_r   <= released_nxt_s;
      level_done_r <= level_done_nxt_s;
      trunc_r      <= trunc_nxt_s;
    end
  end

  assign bus.block_ready     = busy_r;
  assign bus.block_x_center  = x_r;
  assign bus.level_done      = level_done_r;
  assign bus.level_truncated = trunc_r;
  assign bus.blocks_released = released_r;
  assign bus.spawn_state     = to_spawn_state(state_r);

endmodule

// File: tb/tb_block_spawner.sv
// Bench for block_spawner: release scoreboard plus per-entry vector table and
// hand sequences for stall, retire, drain, truncation and reset.
module tb_block_spawner;
  import spawn_pkg::*;

  localparam int NS = 4;

  typedef struct {
    int slot;
    int x;
  } rel_t;

  typedef struct {
    logic [NS-1:0] hit;
    logic [NS-1:0] endm;
    bit            exp_rel;
    int            slot;
    int            x;
    int            count;
  } vec_t;

  logic          frame_clk = 1'b0;
  logic          Reset;
  int            n_checks;
  int            n_fail;
  logic [NS-1:0] prev_rdy;
  rel_t          sb_q[$];
  vec_t          vecs[15];

  always #5 frame_clk = ~frame_clk;

  block_spawner_if #(.NUM_SLOTS(NS)) bus();

  block_spawner #(
    .NUM_SLOTS  (NS),
    .PATTERN_LEN(16),
    .X_BASE     (10'd80),
    .COL_PITCH  (10'd80)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int slot, input int x);
    rel_t r;
    r.slot = slot;
    r.x    = x;
    sb_q.push_back(r);
  endtask

  // One frame; every rising block_ready bit is popped against the scoreboard
  task automatic tick();
    logic [NS-1:0] rise;
    rel_t          e;
    @(posedge frame_clk);
    #1;
    rise = bus.block_ready & ~prev_rdy;
    for (int i = 0; i < NS; i++) begin
      if (rise[i]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_release: slot %0d x %0d, no release expected", i,
                   int'(bus.block_x_center[i]));
        end else begin
          e = sb_q.pop_front();
          check("release_slot", i, e.slot);
          check("release_x", int'(bus.block_x_center[i]), e.x);
        end
      end
    end
    prev_rdy = bus.block_ready;
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) tick();
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic pulse(input logic [NS-1:0] hit, input logic [NS-1:0] endm);
    bus.slot_hit = hit;
    bus.slot_end = endm;
    tick();
    bus.slot_hit = '0;
    bus.slot_end = '0;
  endtask

  // Entry 0 = {gap 3, col 2}: slot 0 must rise on the 4th edge after start
  task automatic start_first();
    push_exp(0, 240);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_state_wait", int'(bus.spawn_state), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("start_not_yet", int'(bus.block_ready[0]), 0);
    end
    check("start_state_release", int'(bus.spawn_state), 2);
    tick();
    check("start_ready0", int'(bus.block_ready[0]), 1);
    check("start_x0", int'(bus.block_x_center[0]), 240);
    check("start_released", int'(bus.blocks_released), 1);
    sb_q.delete();
  endtask

  task automatic run_vec(input int v);
    if (vecs[v].exp_rel) push_exp(vecs[v].slot, vecs[v].x);
    if ((vecs[v].hit | vecs[v].endm) != '0) pulse(vecs[v].hit, vecs[v].endm);
    if (vecs[v].exp_rel) wait_sb_empty(40);
    else repeat (6) tick();
    check($sformatf("vec%0d_released", v), int'(bus.blocks_released), vecs[v].count);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    prev_rdy     = '0;
    bus.start    = 1'b0;
    bus.restart  = 1'b0;
    bus.slot_hit = '0;
    bus.slot_end = '0;

    // {hit, end, release expected, slot, x, blocks_released afterwards}
    vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 1,  80,  2};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 2, 480,  3};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 3, 480,  4};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1, 1, 320,  6};
    vecs[4]  = '{4'b0000, 4'b1000, 1'b0, 0,   0,  6};
    vecs[5]  = '{4'b0001, 4'b0000, 1'b1, 0, 400,  7};
    vecs[6]  = '{4'b0110, 4'b0000, 1'b1, 1, 480,  8};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 2,  80,  9};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 0, 160, 10};
    vecs[9]  = '{4'b0100, 4'b0000, 1'b1, 2, 240, 11};
    vecs[10] = '{4'b0010, 4'b0000, 1'b1, 1, 320, 12};
    vecs[11] = '{4'b0001, 4'b0000, 1'b1, 0, 400, 13};
    vecs[12] = '{4'b0001, 4'b0000, 1'b1, 0, 480, 14};
    vecs[13] = '{4'b0100, 4'b0000, 1'b1, 2,  80, 15};
    vecs[14] = '{4'b0010, 4'b0000, 1'b1, 1, 160, 16};

    Reset = 1'b1;
    #12;
    check("rst_ready", int'(bus.block_ready), 0);
    check("rst_x0", int'(bus.block_x_center[0]), 80);
    check("rst_x3", int'(bus.block_x_center[3]), 80);
    check("rst_done", int'(bus.level_done), 0);
    check("rst_trunc", int'(bus.level_truncated), 0);
    check("rst_released", int'(bus.blocks_released), 0);
    check("rst_state", int'(bus.spawn_state), 0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    tick();
    check("idle_state", int'(bus.spawn_state), 0);

    start_first();
    for (int v = 0; v < 3; v++) run_vec(v);

    // All four slots busy: entry 4 must stall without being consumed
    repeat (6) tick();
    check("stall_state", int'(bus.spawn_state), 2);
    check("stall_released", int'(bus.blocks_released), 4);
    pulse(4'b0100, 4'b0000);
    check("hit2_freed", int'(bus.block_ready[2]), 0);
    push_exp(2, 160);
    tick();
    check("hit2_rerelease", int'(bus.block_ready[2]), 1);
    check("hit2_x", int'(bus.block_x_center[2]), 160);
    check("hit2_released", int'(bus.blocks_released), 5);
    check("sb_after_hit2", sb_q.size(), 0);

    for (int v = 3; v < 15; v++) run_vec(v);

    // Pattern exhausted: drain, then DONE once every slot is idle
    check("drain_state", int'(bus.spawn_state), 3);
    check("drain_not_done", int'(bus.level_done), 0);
    check("retired_x3_stable", int'(bus.block_x_center[3]), 480);
    pulse(4'b0111, 4'b0000);
    check("drain_still_pending", int'(bus.level_done), 0);
    tick();
    check("done_flag", int'(bus.level_done), 1);
    check("done_state", int'(bus.spawn_state), 3);
    check("done_trunc", int'(bus.level_truncated), 0);
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    check("done_ignore_start_state", int'(bus.spawn_state), 3);
    check("done_ignore_start_cnt", int'(bus.blocks_released), 16);
    check("done_ignore_start_ready", int'(bus.block_ready), 0);
    check("done_held", int'(bus.level_done), 1);

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("restart_state", int'(bus.spawn_state), 0);
    check("restart_released", int'(bus.blocks_released), 0);
    check("restart_done", int'(bus.level_done), 0);
    check("restart_x1", int'(bus.block_x_center[1]), 80);

    // Retire every slot with entries left: truncated finish
    start_first();
    push_exp(1, 80);
    wait_sb_empty(40);
    push_exp(2, 480);
    wait_sb_empty(40);
    push_exp(3, 480);
    wait_sb_empty(40);
    pulse(4'b0000, 4'b1111);
    for (int k = 0; k < 20 && bus.level_done !== 1'b1; k++) tick();
    check("trunc_done", int'(bus.level_done), 1);
    check("trunc_flag", int'(bus.level_truncated), 1);
    check("trunc_released", int'(bus.blocks_released), 4);
    check("trunc_state", int'(bus.spawn_state), 3);
    check("trunc_ready", int'(bus.block_ready), 0);

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check("restart2_state", int'(bus.spawn_state), 0);
    check("restart2_released", int'(bus.blocks_released), 0);
    check("restart2_trunc", int'(bus.level_truncated), 0);
    start_first();

    // gap_cnt now 5 with slot 0 busy; Reset mid-cycle must act immediately
    tick();
    check("midwait_state", int'(bus.spawn_state), 1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_ready", int'(bus.block_ready), 0);
    check("async_rst_x0", int'(bus.block_x_center[0]), 80);
    check("async_rst_released", int'(bus.blocks_released), 0);
    check("async_rst_state", int'(bus.spawn_state), 0);
    check("async_rst_done", int'(bus.level_done), 0);
    check("sb_final_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
